// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter.
package ps2_host_tx_pkg;

  localparam int unsigned TIMEOUT_W = 20;
  localparam int unsigned FRAME_W   = 10;
  localparam int unsigned BITCNT_W  = 4;

  // Common command/response bytes, shared with the receiver side.
  localparam logic [7:0] PS2_CMD_SETLED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_ACK        = 8'hFA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_BITS,
    ST_ACK,
    ST_WAITIDLE
  } ps2_tx_state_t;

  // Bits after the start bit, shifted out LSB first.
  typedef struct packed {
    logic       stop;
    logic       parity;
    logic [7:0] data;
  } ps2_frame_t;

  // Odd parity: parity bit makes the total count of ones odd.
  function automatic ps2_frame_t build_frame(input logic [7:0] d);
    ps2_frame_t f;
    f.stop   = 1'b1;
    f.parity = ~^d;
    f.data   = d;
    return f;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Host-side request/status handshake of the PS/2 transmitter.
interface ps2_host_tx_if;
  logic [7:0] data;
  logic       send;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    output data,
    output send,
    input  busy,
    input  done,
    input  error
  );

  modport slave (
    input  data,
    input  send,
    output busy,
    output done,
    output error
  );
endinterface

// File: rtl/ps2_host_tx_line_sync.sv
// Synchroniser, stability filter and falling-edge strobe for one PS/2 line.
module ps2_host_tx_line_sync #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic level,
  output logic fall
);

  localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

  logic             meta;
  logic             sync;
  logic [CNT_W-1:0] cnt;

  // Level follows the synchronised line only after FILTER_LEN differing samples in a row.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta  <= 1'b1;
      sync  <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      meta <= line;
      sync <= meta;
      fall <= 1'b0;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
        level <= sync;
        fall  <= ~sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out one byte, check ACK.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 2800,
  parameter int unsigned TIMEOUT_CYCLES = 420000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ps2clk_ext,
  input  logic               ps2data_ext,
  output logic               ps2clk_oe,
  output logic               ps2data_oe,
  ps2_host_tx_if.slave       host
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);

  ps2_tx_state_t        state, state_n;
  logic [FRAME_W-1:0]   shift, shift_n;
  logic [BITCNT_W-1:0]  bitcnt, bitcnt_n;
  logic [INH_W-1:0]     inh_cnt, inh_n;
  logic [TIMEOUT_W-1:0] to_cnt, to_n;
  logic                 clk_oe_n, data_oe_n;
  logic                 busy_q, busy_n;
  logic                 done_q, done_n;
  logic                 error_q, error_n;
  logic                 timed;

  logic clk_level, clk_fall;
  logic data_level, data_fall_unused;

  ps2_host_tx_line_sync #(.FILTER_LEN(FILTER_LEN)) u_clk_sync (
    .clk   (clk),
    .rst   (rst),
    .line  (ps2clk_ext),
    .level (clk_level),
    .fall  (clk_fall)
  );

  ps2_host_tx_line_sync #(.FILTER_LEN(FILTER_LEN)) u_data_sync (
    .clk   (clk),
    .rst   (rst),
    .line  (ps2data_ext),
    .level (data_level),
    .fall  (data_fall_unused)
  );

  assign host.busy  = busy_q;
  assign host.done  = done_q;
  assign host.error = error_q;

  // State and datapath registers; reset releases both lines immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      shift      <= '0;
      bitcnt     <= '0;
      inh_cnt    <= '0;
      to_cnt     <= '0;
      ps2clk_oe  <= 1'b0;
      ps2data_oe <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state      <= state_n;
      shift      <= shift_n;
      bitcnt     <= bitcnt_n;
      inh_cnt    <= inh_n;
      to_cnt     <= to_n;
      ps2clk_oe  <= clk_oe_n;
      ps2data_oe <= data_oe_n;
      busy_q     <= busy_n;
      done_q     <= done_n;
      error_q    <= error_n;
    end
  end

  // Next-state and next-output logic; timeout overrides everything once the clock is released.
  always_comb begin
    state_n   = state;
    shift_n   = shift;
    bitcnt_n  = bitcnt;
    inh_n     = inh_cnt;
    to_n      = to_cnt;
    clk_oe_n  = ps2clk_oe;
    data_oe_n = ps2data_oe;
    busy_n    = (state != ST_IDLE);
    done_n    = 1'b0;
    error_n   = 1'b0;
    timed     = (state == ST_START) || (state == ST_BITS) ||
                (state == ST_ACK)   || (state == ST_WAITIDLE);

    if (timed && (to_cnt != {TIMEOUT_W{1'b1}})) begin
      to_n = to_cnt + TIMEOUT_W'(1);
    end

    case (state)
      ST_IDLE: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        if (host.send) begin
          shift_n  = build_frame(host.data);
          bitcnt_n = '0;
          inh_n    = '0;
          to_n     = '0;
          clk_oe_n = 1'b1;
          busy_n   = 1'b1;
          state_n  = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        if (ps2data_oe) begin
          clk_oe_n = 1'b0;
          to_n     = '0;
          state_n  = ST_START;
        end else if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
          data_oe_n = 1'b1;
        end else begin
          inh_n = inh_cnt + INH_W'(1);
        end
      end

      ST_START, ST_BITS: begin
        if (clk_fall) begin
          data_oe_n = ~shift[0];
          shift_n   = {1'b0, shift[FRAME_W-1:1]};
          bitcnt_n  = bitcnt + BITCNT_W'(1);
          if (state == ST_START) begin
            state_n = ST_BITS;
          end else if (bitcnt == BITCNT_W'(FRAME_W - 1)) begin
            state_n = ST_ACK;
          end
        end
      end

      ST_ACK: begin
        if (clk_fall) begin
          if (!data_level) begin
            state_n = ST_WAITIDLE;
          end else begin
            error_n   = 1'b1;
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
            state_n   = ST_IDLE;
          end
        end
      end

      ST_WAITIDLE: begin
        if (clk_level && data_level) begin
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end
      end

      default: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        state_n   = ST_IDLE;
      end
    endcase

    if (timed && (to_cnt >= TIMEOUT_W'(TIMEOUT_CYCLES - 1))) begin
      done_n    = 1'b0;
      error_n   = 1'b1;
      clk_oe_n  = 1'b0;
      data_oe_n = 1'b0;
      state_n   = ST_IDLE;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model on the wired-AND lines.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int unsigned INH  = 40;
  localparam int unsigned TO   = 3000;
  localparam int unsigned FL   = 4;
  localparam int          HALF = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  logic ps2clk_ext, ps2data_ext;
  logic ps2clk_oe, ps2data_oe;

  int checks = 0;
  int failures = 0;
  int n_done = 0;
  int n_err = 0;
  int n_both = 0;

  always #5 clk = ~clk;

  ps2_host_tx_if host ();

  assign ps2clk_ext  = dev_clk  & ~ps2clk_oe;
  assign ps2data_ext = dev_data & ~ps2data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO),
    .FILTER_LEN     (FL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2clk_ext  (ps2clk_ext),
    .ps2data_ext (ps2data_ext),
    .ps2clk_oe   (ps2clk_oe),
    .ps2data_oe  (ps2data_oe),
    .host        (host)
  );

  // Pulse counters for done/error, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (host.done) n_done++;
      if (host.error) n_err++;
      if (host.done && host.error) n_both++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Request a byte, then time start bit and clock release in cycles after acceptance.
  task automatic start_frame(input logic [7:0] d, input bit inject, input logic [7:0] d2,
                             output int t_data, output int t_rel);
    @(negedge clk);
    host.data = d;
    host.send = 1'b1;
    @(negedge clk);
    host.send = 1'b0;
    t_data = -1;
    t_rel  = -1;
    for (int k = 1; k <= int'(INH) + 20; k++) begin
      if (t_data < 0 && ps2data_oe) t_data = k;
      if (!ps2clk_oe) begin
        t_rel = k;
        break;
      end
      if (inject && k == 5) begin
        host.data = d2;
        host.send = 1'b1;
      end
      if (k == 6) host.send = 1'b0;
      @(negedge clk);
    end
  endtask

  // Device clocks n_falls pulses, reading the line at each rising edge; optional ACK on pulse 11.
  task automatic dev_clock(input int n_falls, input bit ack,
                           output logic [9:0] bits, output logic start_bit);
    bits = '0;
    repeat (HALF) @(negedge clk);
    start_bit = ps2data_ext;
    for (int i = 1; i <= n_falls; i++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      if (i <= 10) bits[i-1] = ps2data_ext;
      if (i == 10 && ack) begin
        repeat (HALF / 2) @(negedge clk);
        dev_data = 1'b0;
        repeat (HALF / 2) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      if (i == 11) dev_data = 1'b1;
    end
  endtask

  logic [9:0] bits;
  logic       sb;
  int         td, tr, d0, e0, t_err;

  initial begin
    host.data = '0;
    host.send = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_clk_oe", ps2clk_oe, 0);
    check("rst_data_oe", ps2data_oe, 0);
    check("rst_busy", host.busy, 0);
    check("rst_done", host.done, 0);
    check("rst_error", host.error, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // 1: set-LEDs command with ACK
    d0 = n_done; e0 = n_err;
    start_frame(PS2_CMD_SETLED, 1'b0, 8'h00, td, tr);
    check("t1_start_latency", td, INH + 1);
    check("t1_release", tr, INH + 2);
    check("t1_busy", host.busy, 1);
    dev_clock(11, 1'b1, bits, sb);
    check("t1_start_bit", sb, 0);
    check("t1_frame", bits, 10'h3ED);
    repeat (60) @(negedge clk);
    check("t1_done", n_done - d0, 1);
    check("t1_err", n_err - e0, 0);
    check("t1_busy_low", host.busy, 0);

    // 2: zero byte, parity must be 1
    d0 = n_done;
    start_frame(8'h00, 1'b0, 8'h00, td, tr);
    dev_clock(11, 1'b1, bits, sb);
    check("t2_parity", bits[8], 1);
    check("t2_frame", bits, 10'h300);
    repeat (60) @(negedge clk);
    check("t2_done", n_done - d0, 1);

    // 3: device never clocks -> timeout
    d0 = n_done; e0 = n_err; t_err = -1;
    start_frame(8'h55, 1'b0, 8'h00, td, tr);
    for (int j = 1; j <= 2 * int'(TO); j++) begin
      @(negedge clk);
      if (host.error) begin
        t_err = j;
        break;
      end
    end
    check("t3_timeout", t_err, TO);
    check("t3_clk_oe", ps2clk_oe, 0);
    check("t3_data_oe", ps2data_oe, 0);
    repeat (10) @(negedge clk);
    check("t3_err", n_err - e0, 1);
    check("t3_done", n_done - d0, 0);

    // 4: no ACK from device
    d0 = n_done; e0 = n_err;
    start_frame(8'hA5, 1'b0, 8'h00, td, tr);
    dev_clock(11, 1'b0, bits, sb);
    repeat (60) @(negedge clk);
    check("t4_err", n_err - e0, 1);
    check("t4_done", n_done - d0, 0);
    check("t4_busy", host.busy, 0);
    check("t4_oe", {ps2clk_oe, ps2data_oe}, 0);

    // 5: second request while busy is dropped
    d0 = n_done; e0 = n_err;
    start_frame(PS2_CMD_SETLED, 1'b1, PS2_CMD_RESET, td, tr);
    dev_clock(11, 1'b1, bits, sb);
    check("t5_frame", bits, 10'h3ED);
    repeat (60) @(negedge clk);
    check("t5_done", n_done - d0, 1);
    repeat (INH + 10) @(negedge clk);
    check("t5_no_requeue", {ps2clk_oe, host.busy}, 0);

    // 6: reset in the middle of the data bits
    d0 = n_done; e0 = n_err;
    start_frame(PS2_CMD_SETLED, 1'b0, 8'h00, td, tr);
    dev_clock(4, 1'b0, bits, sb);
    rst = 1'b1;
    @(negedge clk);
    check("t6_clk_oe", ps2clk_oe, 0);
    check("t6_data_oe", ps2data_oe, 0);
    check("t6_busy", host.busy, 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("t6_no_pulse", (n_done - d0) + (n_err - e0), 0);
    start_frame(8'h00, 1'b0, 8'h00, td, tr);
    dev_clock(11, 1'b1, bits, sb);
    check("t6_frame", bits, 10'h300);
    repeat (60) @(negedge clk);
    check("t6_done", n_done - d0, 1);

    check("never_both", n_both, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
